// File: rtl/bnn_host_driver.sv
// bnn_host_driver: drives a serial-load BNN chip from byte streams.
// Parameter bytes shift in MSB first; input vectors go out as two nibbles.
module bnn_host_driver #(
    parameter int PARAM_BYTES = 8,
    parameter int CLK_DIV     = 2,
    parameter int SAMPLE_DLY  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [7:0] cfg_data,
    input  logic       vec_valid,
    output logic       vec_ready,
    input  logic [7:0] vec_data,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       pin_clk,
    output logic       pin_setup,
    output logic       pin_param,
    output logic       pin_bank_hi,
    output logic [3:0] pin_x,
    input  logic [7:0] pin_out,
    output logic       loaded,
    output logic       busy
);

    localparam int SLOT = 2 * CLK_DIV;
    localparam int SW   = $clog2(SLOT);
    localparam int DW   = (SAMPLE_DLY > 1) ? $clog2(SAMPLE_DLY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_SHIFT,
        S_LOAD_WAIT,
        S_EVAL_LO,
        S_EVAL_HI,
        S_SETTLE,
        S_RESULT
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    byte_cnt_q, byte_cnt_d;
    logic [DW-1:0] dly_q, dly_d;
    logic [7:0]    cfg_q, cfg_d;
    logic [7:0]    vec_q, vec_d;
    logic [7:0]    res_q, res_d;
    logic          loaded_q, loaded_d;

    logic          slot_last;
    logic          clk_hi;
    logic [2:0]    bit_idx;
    logic [7:0]    byte_inc;

    assign slot_last = (slot_q == SW'(SLOT - 1));
    assign clk_hi    = (slot_q >= SW'(CLK_DIV));
    assign bit_idx   = 3'd7 - bit_q;
    assign byte_inc  = byte_cnt_q + 8'd1;

    assign busy      = (state_q != S_IDLE);
    assign loaded    = loaded_q;
    assign res_valid = (state_q == S_RESULT);
    assign res_data  = res_q;
    assign cfg_ready = (state_q == S_IDLE) || (state_q == S_LOAD_WAIT);
    // cfg has priority in IDLE, so vec is refused while cfg_valid is up
    assign vec_ready = (state_q == S_IDLE) && loaded_q && !cfg_valid;

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            slot_q     <= '0;
            bit_q      <= '0;
            byte_cnt_q <= '0;
            dly_q      <= '0;
            cfg_q      <= '0;
            vec_q      <= '0;
            res_q      <= '0;
            loaded_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            bit_q      <= bit_d;
            byte_cnt_q <= byte_cnt_d;
            dly_q      <= dly_d;
            cfg_q      <= cfg_d;
            vec_q      <= vec_d;
            res_q      <= res_d;
            loaded_q   <= loaded_d;
        end
    end

    // Next-state: slot sequencing, byte counting, result capture
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        bit_d      = bit_q;
        byte_cnt_d = byte_cnt_q;
        dly_d      = dly_q;
        cfg_d      = cfg_q;
        vec_d      = vec_q;
        res_d      = res_q;
        loaded_d   = loaded_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    cfg_d      = cfg_data;
                    byte_cnt_d = '0;
                    loaded_d   = 1'b0;
                    bit_d      = '0;
                    slot_d     = '0;
                    state_d    = S_LOAD_SHIFT;
                end else if (vec_valid && loaded_q) begin
                    vec_d   = vec_data;
                    slot_d  = '0;
                    state_d = S_EVAL_LO;
                end
            end
            S_LOAD_SHIFT: begin
                if (slot_last) begin
                    slot_d = '0;
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        byte_cnt_d = byte_inc;
                        if (byte_inc == 8'(PARAM_BYTES)) begin
                            loaded_d = 1'b1;
                            state_d  = S_IDLE;
                        end else begin
                            state_d = S_LOAD_WAIT;
                        end
                    end
                end else begin
                    slot_d = slot_q + SW'(1);
                end
            end
            S_LOAD_WAIT: begin
                if (cfg_valid) begin
                    cfg_d   = cfg_data;
                    bit_d   = '0;
                    slot_d  = '0;
                    state_d = S_LOAD_SHIFT;
                end
            end
            S_EVAL_LO: begin
                if (slot_last) begin
                    slot_d  = '0;
                    state_d = S_EVAL_HI;
                end else begin
                    slot_d = slot_q + SW'(1);
                end
            end
            S_EVAL_HI: begin
                if (slot_last) begin
                    slot_d  = '0;
                    dly_d   = '0;
                    state_d = S_SETTLE;
                end else begin
                    slot_d = slot_q + SW'(1);
                end
            end
            S_SETTLE: begin
                if (dly_q == DW'(SAMPLE_DLY - 1)) begin
                    res_d   = pin_out;
                    state_d = S_RESULT;
                end else begin
                    dly_d = dly_q + DW'(1);
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Chip pins decoded from state; data only moves at slot start
    always_comb begin
        pin_clk     = 1'b0;
        pin_setup   = 1'b0;
        pin_param   = 1'b0;
        pin_bank_hi = 1'b0;
        pin_x       = '0;
        case (state_q)
            S_LOAD_SHIFT: begin
                pin_clk   = clk_hi;
                pin_setup = 1'b1;
                pin_param = cfg_q[bit_idx];
            end
            S_LOAD_WAIT: begin
                pin_setup = 1'b1;
                pin_param = cfg_q[0];
            end
            S_EVAL_LO: begin
                pin_clk = clk_hi;
                pin_x   = vec_q[3:0];
            end
            S_EVAL_HI: begin
                pin_clk     = clk_hi;
                pin_bank_hi = 1'b1;
                pin_x       = vec_q[7:4];
            end
            S_SETTLE: begin
                pin_bank_hi = 1'b1;
                pin_x       = vec_q[7:4];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bnn_host_driver.sv
// tb_bnn_host_driver: directed checks of load, eval and reset behaviour.
// Default parameters: 8 bytes, CLK_DIV=2, SAMPLE_DLY=4.
module tb_bnn_host_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_data;
    logic       vec_valid;
    logic       vec_ready;
    logic [7:0] vec_data;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       pin_clk;
    logic       pin_setup;
    logic       pin_param;
    logic       pin_bank_hi;
    logic [3:0] pin_x;
    logic [7:0] pin_out;
    logic       loaded;
    logic       busy;

    always #5 clk = ~clk;

    bnn_host_driver dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_data   (cfg_data),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready),
        .vec_data   (vec_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .pin_clk    (pin_clk),
        .pin_setup  (pin_setup),
        .pin_param  (pin_param),
        .pin_bank_hi(pin_bank_hi),
        .pin_x      (pin_x),
        .pin_out    (pin_out),
        .loaded     (loaded),
        .busy       (busy)
    );

    int   checks = 0;
    int   failures = 0;

    logic pclk_prev = 1'b0;
    int   edges = 0;
    int   setup_bad = 0;
    logic bitlog[$];

    logic [7:0] pbytes [8] = '{8'hA5, 8'h3C, 8'hE1, 8'h0F,
                               8'h81, 8'h7E, 8'h55, 8'hC3};

    // Pin-clock edge monitor: log pin_param at each rising pin_clk
    always @(negedge clk) begin
        if (pin_clk && !pclk_prev) begin
            edges++;
            bitlog.push_back(pin_param);
            if (!pin_setup) setup_bad++;
        end
        pclk_prev = pin_clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input string pfx, input int gap_after,
                           input int gap_len);
        int          b0;
        int          e0;
        int          s0;
        int          n;
        int          tmo;
        int          gap_bad;
        logic [63:0] obs;
        logic [63:0] exp;
        b0      = bitlog.size();
        e0      = edges;
        s0      = setup_bad;
        tmo     = 0;
        gap_bad = 0;
        exp     = '0;
        for (int i = 0; i < 8; i++) begin
            if (i == gap_after) begin
                n = 0;
                while (!cfg_ready && n < 100) begin step(); n++; end
                if (n >= 100) tmo++;
                for (int g = 0; g < gap_len; g++) begin
                    if (pin_clk !== 1'b0 || pin_setup !== 1'b1 ||
                        pin_param !== pbytes[i-1][0]) gap_bad++;
                    step();
                end
            end
            cfg_valid = 1'b1;
            cfg_data  = pbytes[i];
            n = 0;
            while (!cfg_ready && n < 100) begin step(); n++; end
            if (n >= 100) tmo++;
            step();
            cfg_valid = 1'b0;
            cfg_data  = 8'h00;
            exp = {exp[55:0], pbytes[i]};
        end
        n = 0;
        while (!loaded && n < 100) begin step(); n++; end
        if (n >= 100) tmo++;
        obs = 'x;
        if (bitlog.size() >= b0 + 64) begin
            for (int k = 0; k < 64; k++) obs[63-k] = bitlog[b0+k];
        end
        chk({pfx, "_timeout"}, 64'(tmo), 64'd0);
        chk({pfx, "_edges"}, 64'(edges - e0), 64'd64);
        chk({pfx, "_bits"}, obs, exp);
        chk({pfx, "_setup_hi"}, 64'(setup_bad - s0), 64'd0);
        chk({pfx, "_loaded"}, 64'(loaded), 64'd1);
        chk({pfx, "_idle_pins"},
            64'({pin_clk, pin_setup, pin_param, pin_bank_hi, pin_x, busy}),
            64'd0);
        if (gap_after > 0) chk({pfx, "_gap_pins"}, 64'(gap_bad), 64'd0);
    endtask

    initial begin
        int          n;
        int          e0;
        int          vbad;
        int          first_rv;
        int          hold_bad;
        logic [11:0] clk_tr;
        logic [11:0] bank_tr;
        logic [47:0] x_tr;

        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
        vec_valid = 1'b0;
        vec_data  = 8'h00;
        res_ready = 1'b0;
        pin_out   = 8'h00;
        step();
        step();
        chk("rst_pins",
            64'({pin_clk, pin_setup, pin_param, pin_bank_hi, pin_x}), 64'd0);
        chk("rst_flags", 64'({loaded, busy, res_valid}), 64'd0);
        chk("rst_res_data", 64'(res_data), 64'd0);
        chk("rst_ready", 64'({cfg_ready, vec_ready}), 64'b10);
        rst = 1'b0;

        // vec with no parameters loaded must be ignored
        vec_valid = 1'b1;
        vec_data  = 8'h77;
        e0   = edges;
        vbad = 0;
        for (int c = 0; c < 20; c++) begin
            if (vec_ready !== 1'b0 || busy !== 1'b0) vbad++;
            step();
        end
        vec_valid = 1'b0;
        chk("noload_vec_ready", 64'(vbad), 64'd0);
        chk("noload_edges", 64'(edges - e0), 64'd0);

        do_load("load1", -1, 0);
        do_load("load_gap", 3, 10);

        // Evaluate 0x3C against chip output 0x5A
        pin_out   = 8'h5A;
        vec_valid = 1'b1;
        vec_data  = 8'h3C;
        chk("eval_vec_ready", 64'(vec_ready), 64'd1);
        step();
        vec_valid = 1'b0;
        vec_data  = 8'hFF;
        first_rv  = -1;
        clk_tr    = 'x;
        bank_tr   = 'x;
        x_tr      = 'x;
        for (int c = 1; c <= 20; c++) begin
            if (c <= 12) begin
                clk_tr[c-1]       = pin_clk;
                bank_tr[c-1]      = pin_bank_hi;
                x_tr[4*(c-1) +: 4] = pin_x;
            end
            if (res_valid && first_rv < 0) first_rv = c;
            if (first_rv >= 0) break;
            step();
        end
        chk("eval_pin_clk", 64'(clk_tr), 64'h0CC);
        chk("eval_bank", 64'(bank_tr), 64'hFF0);
        chk("eval_pin_x", 64'(x_tr), 64'h3333_3333_CCCC);
        chk("eval_latency", 64'(first_rv), 64'd13);
        chk("eval_res_data", 64'(res_data), 64'h5A);

        pin_out  = 8'hA5;
        hold_bad = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (res_valid !== 1'b1 || res_data !== 8'h5A) hold_bad++;
        end
        chk("res_hold", 64'(hold_bad), 64'd0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("res_done", 64'({res_valid, busy, pin_bank_hi, pin_x}), 64'd0);

        // Simultaneous cfg and vec: cfg wins
        cfg_valid = 1'b1;
        cfg_data  = 8'h11;
        vec_valid = 1'b1;
        vec_data  = 8'h22;
        step();
        cfg_valid = 1'b0;
        vec_valid = 1'b0;
        chk("both_state",
            64'({loaded, busy, cfg_ready, pin_setup, pin_bank_hi}),
            64'b01010);

        // Reset in the middle of a byte
        for (int c = 0; c < 5; c++) step();
        chk("mid_setup", 64'(pin_setup), 64'd1);
        rst = 1'b1;
        step();
        chk("midrst_pins",
            64'({pin_clk, pin_setup, pin_param, pin_bank_hi, pin_x}), 64'd0);
        chk("midrst_flags", 64'({loaded, busy}), 64'd0);
        rst = 1'b0;
        step();
        do_load("reload", -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bnn_host_driver.md
BNN_HOST_DRIVER -- requirements
Module: bnn_host_driver

Interface
REQ-001 Parameter PARAM_BYTES, default 8: number of parameter bytes per complete chip load (1..255).
REQ-002 Parameter CLK_DIV, default 2: pin-clock half period in clk cycles (>=1).
REQ-003 Parameter SAMPLE_DLY, default 4: clk cycles between the last pin-clock slot and result capture (>=1).
REQ-004 clk  input  1  the single clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cfg_valid / cfg_ready / cfg_data  in / out / in  1/1/8  parameter byte stream, shifted MSB first.
REQ-007 vec_valid / vec_ready / vec_data  in / out / in  1/1/8  input vector byte.
REQ-008 res_valid / res_ready / res_data  out / in / out  1/1/8  inference result.
REQ-009 pin_clk, pin_setup, pin_param, pin_bank_hi  output  1 each  chip clock, setup mode, serial parameter bit, nibble bank select.
REQ-010 pin_x  output  4  input nibble to chip.
REQ-011 pin_out  input  8  chip output bus.
REQ-012 loaded  output  1  complete parameter set has been shifted in.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 States: IDLE, LOAD_SHIFT, LOAD_WAIT, EVAL_LO, EVAL_HI, SETTLE, RESULT.
REQ-015 Slot: 2*CLK_DIV cycles; pin_clk low for the first CLK_DIV, high for the last CLK_DIV; pin data changes only on the first cycle of a slot.
REQ-016 cfg_ready high only in IDLE and LOAD_WAIT; vec_ready high only in IDLE with loaded=1.
REQ-017 IDLE: cfg_valid and vec_valid both high -> cfg wins; vec not accepted.
REQ-018 cfg accept in IDLE -> clear loaded, clear byte counter, go LOAD_SHIFT; pin_setup=1 from next cycle until load completes.
REQ-019 LOAD_SHIFT: 8 slots, pin_param = byte bit 7 down to bit 0; after the 8th slot increment byte counter; counter==PARAM_BYTES -> set loaded, pin_setup=0, IDLE; else LOAD_WAIT.
REQ-020 LOAD_WAIT: pin_clk=0, pin_setup=1, pin_param held; cfg accept -> LOAD_SHIFT next cycle; unbounded stall permitted.
REQ-021 vec accept at cycle t -> EVAL_LO slot cycles t+1..t+2*CLK_DIV: pin_bank_hi=0, pin_x=vec_data[3:0].
REQ-022 EVAL_HI: next slot, pin_bank_hi=1, pin_x=vec_data[7:4].
REQ-023 SETTLE: SAMPLE_DLY cycles, pin_clk=0, pin_bank_hi/pin_x held; res_data captures pin_out at the edge ending the last SETTLE cycle.
REQ-024 RESULT: res_valid=1, res_data stable until res_ready; handshake -> IDLE next cycle; res_valid drops same edge.
REQ-025 Latency with defaults: vec accept at t -> res_valid first high at t+13.
REQ-026 IDLE outputs: pin_clk, pin_setup, pin_param, pin_bank_hi =0; pin_x=0.
REQ-027 vec_data/cfg_data registered at acceptance; later input changes have no effect.
REQ-028 Slot and delay counters sized for parameter values; no wrap inside a slot.

Reset
REQ-029 rst high -> next edge: state IDLE, all pin_* outputs 0, loaded=0, busy=0, res_valid=0, res_data=0, cfg_ready=1, vec_ready=0.
REQ-030 rst during LOAD_* discards partial load (loaded=0); rst during EVAL/SETTLE/RESULT drops result; rst overrides every handshake in the same cycle.

Verification
REQ-031 Reset, then vec_valid=1 with loaded=0 -> vec_ready stays 0, no pin_clk edges.
REQ-032 Load 8 bytes 0xA5.. back-to-back, defaults -> 64 pin_clk rising edges, pin_param sampled at each = byte bits MSB first, pin_setup high throughout, loaded=1 after last slot.
REQ-033 Load with 10-cycle cfg_valid gap after byte 3 -> pin_clk held 0 and pin_setup 1 during gap; captured bit stream unchanged.
REQ-034 loaded=1, vec_data=0x3C at t, pin_out model=0x5A -> pin_x=0xC bank 0 then 0x3 bank 1, res_valid at t+13, res_data=0x5A; res_ready low 5 cycles -> data held.
REQ-035 cfg_valid and vec_valid simultaneously in IDLE with loaded=1 -> cfg accepted, loaded drops to 0.
REQ-036 rst asserted in mid-byte of LOAD_SHIFT -> next cycle all pins 0, loaded=0; subsequent full load succeeds.
